// File: rtl/regfile_bank.sv
// regfile_bank: DEPTH x WIDTH register bank, one synchronous write port and
// two combinational read ports built as binary trees of 2:1 selectors.
// The last register (DEPTH-1) has no storage and always reads zero.
// Optional macro REGFILE_BYPASS_EN adds a final same-cycle write-forwarding
// stage on each read port (write-before-read).

// One read port: DEPTH:1 selection as a heap-ordered binary tree.
// Node 0 is the root, node i has children 2i+1 (addr bit 0) and 2i+2 (addr
// bit 1); leaves occupy nodes DEPTH-1 .. 2*DEPTH-2 in register order, so the
// leaf level is steered by the address LSB and the root by the MSB.
module regfile_bank_rdport #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]                i_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  i_leaves,
    output logic [WIDTH-1:0]             o_data
);
    localparam int NODES = 2*DEPTH - 1;

    logic [NODES-1:0][WIDTH-1:0] w_node;

    genvar g;
    generate
        // leaves: register values in index order
        for (g = 0; g < DEPTH; g++) begin : g_leaf
            assign w_node[DEPTH-1+g] = i_leaves[g];
        end
        // internal nodes: depth d from root uses address bit AW-1-d
        for (g = 0; g < DEPTH-1; g++) begin : g_mux
            localparam int LVL = $clog2(g + 2) - 1;
            localparam int BIT = AW - 1 - LVL;
            assign w_node[g] = i_addr[BIT] ? w_node[2*g+2] : w_node[2*g+1];
        end
    endgenerate

    assign o_data = w_node[0];
endmodule

module regfile_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_a,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]           rd_data_a,
    output logic [WIDTH-1:0]           rd_data_b
);
    localparam int           AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] ZADDR = AW'(DEPTH - 1);

    // storage only for registers 0..DEPTH-2
    logic [DEPTH-2:0][WIDTH-1:0] r_regs;
    logic [DEPTH-1:0][WIDTH-1:0] w_leaf;
    logic [1:0][AW-1:0]          w_rd_addr;
    logic [1:0][WIDTH-1:0]       w_tree;
    logic [1:0][WIDTH-1:0]       w_rd_data;

    // write port; reset clears all storage immediately and blocks writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                if (wr_addr == AW'(i)) r_regs[i] <= wr_data;
            end
        end
    end

    // leaf vector: stored registers plus the hardwired zero register
    assign w_leaf = {{WIDTH{1'b0}}, r_regs};

    assign w_rd_addr = {rd_addr_b, rd_addr_a};

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_port
            regfile_bank_rdport #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_rdport (
                .i_addr   (w_rd_addr[p]),
                .i_leaves (w_leaf),
                .o_data   (w_tree[p])
            );
`ifdef REGFILE_BYPASS_EN
            // forward the in-flight write; never for the zero register or in reset
            logic w_fwd;
            assign w_fwd = reset_n && wr_en && (wr_addr != ZADDR) &&
                           (w_rd_addr[p] == wr_addr);
            assign w_rd_data[p] = w_fwd ? wr_data : w_tree[p];
`else
            assign w_rd_data[p] = w_tree[p];
`endif
        end
    endgenerate

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;

    int n_cmp = 0;
    int n_err = 0;

    regfile_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic write_one(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        write_one(3'd3, 16'h1234);
        rd_addr_a = 3'd3; #1;
        n_cmp++;
        if (rd_data_a !== 16'h1234) begin
            n_err++; $display("FAIL preload3 got=%h exp=%h", rd_data_a, 16'h1234);
        end
        @(posedge clk); #3;
        reset_n = 1'b0; #1;
        n_cmp++;
        if (rd_data_a !== 16'h0000) begin
            n_err++; $display("FAIL reset_immediate got=%h exp=%h", rd_data_a, 16'h0000);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH-1-i); #1;
            n_cmp++;
            if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
                n_err++; $display("FAIL reset_all a=%0d got=%h/%h exp=0000/0000", i, rd_data_a, rd_data_b);
            end
        end
        @(negedge clk); #2;
        reset_n = 1'b1;
    endtask

    task automatic test_sweep;
        for (int i = 0; i < DEPTH-1; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'hA000 + 16'(i);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH-2-i); #1;
            n_cmp++;
            if (rd_data_a !== 16'hA000 + 16'(i) || rd_data_b !== 16'hA000 + 16'(DEPTH-2-i)) begin
                n_err++;
                $display("FAIL sweep i=%0d got=%h/%h exp=%h/%h", i, rd_data_a, rd_data_b,
                         16'hA000 + 16'(i), 16'hA000 + 16'(DEPTH-2-i));
            end
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        rd_addr_a = 3'd7; rd_addr_b = 3'd7; #1;
        n_cmp++;
        if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
            n_err++; $display("FAIL zero_pre_edge got=%h/%h exp=0000/0000", rd_data_a, rd_data_b);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        n_cmp++;
        if (rd_data_a !== 16'h0) begin
            n_err++; $display("FAIL zero_post_edge got=%h exp=0000", rd_data_a);
        end
        for (int i = 0; i < DEPTH-1; i++) begin
            rd_addr_b = AW'(i); #1;
            n_cmp++;
            if (rd_data_b !== 16'hA000 + 16'(i)) begin
                n_err++; $display("FAIL zero_untouched i=%0d got=%h exp=%h", i, rd_data_b, 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_wren_low;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 3'd2; wr_data = 16'h5555;
        repeat (3) @(posedge clk);
        #1;
        rd_addr_a = 3'd2; #1;
        n_cmp++;
        if (rd_data_a !== 16'hA002) begin
            n_err++; $display("FAIL wren_low got=%h exp=%h", rd_data_a, 16'hA002);
        end
    endtask

    task automatic test_same_cycle;
        logic [WIDTH-1:0] exp_pre;
        write_one(3'd4, 16'h00AA);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0BB0;
        rd_addr_a = 3'd4; rd_addr_b = 3'd4; #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 16'h0BB0;
`else
        exp_pre = 16'h00AA;
`endif
        n_cmp++;
        if (rd_data_a !== exp_pre || rd_data_b !== exp_pre) begin
            n_err++; $display("FAIL same_cycle_pre got=%h/%h exp=%h", rd_data_a, rd_data_b, exp_pre);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; #1;
        n_cmp++;
        if (rd_data_a !== 16'h0BB0 || rd_data_b !== 16'h0BB0) begin
            n_err++; $display("FAIL same_cycle_post got=%h/%h exp=0bb0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_reset_during_write;
        rd_addr_a = 3'd1; #1;
        n_cmp++;
        if (rd_data_a !== 16'hA001) begin
            n_err++; $display("FAIL rdw_before got=%h exp=a001", rd_data_a);
        end
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
        #2 reset_n = 1'b0; #1;
        n_cmp++;
        if (rd_data_a !== 16'h0) begin
            n_err++; $display("FAIL rdw_in_reset got=%h exp=0000", rd_data_a);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (rd_data_a !== 16'h0) begin
            n_err++; $display("FAIL rdw_after_edge got=%h exp=0000", rd_data_a);
        end
        wr_en = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1; #1;
        n_cmp++;
        if (rd_data_a !== 16'h0) begin
            n_err++; $display("FAIL rdw_released got=%h exp=0000", rd_data_a);
        end
        // first edge after release accepts a write
        write_one(3'd1, 16'h3C3C);
        n_cmp++;
        if (rd_data_a !== 16'h3C3C) begin
            n_err++; $display("FAIL rdw_first_write got=%h exp=3c3c", rd_data_a);
        end
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        #12 reset_n = 1'b1;
        test_reset();
        test_sweep();
        test_zero_reg();
        test_wren_low();
        test_same_cycle();
        test_reset_during_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
